// File: rtl/cal_frame_ctrl.sv
// Frame-level sequencer for the channel-gain datapath: arms on request, aligns to an
// FFT frame boundary, gates the datapath per bin, tracks results and publishes the frame-average gain.
module cal_frame_ctrl #(
    parameter int NFFT      = 2048,
    parameter int LOG2_NFFT = 11,
    parameter int PIPE_LAT  = 40,
    parameter int MAG_W     = 13,
    parameter int GAIN_W    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              fft_valid,
    input  logic              fft_last,
    input  logic              divisor_zero,
    output logic              dp_ce,
    output logic              dp_in_valid,
    input  logic              mag_valid,
    input  logic [MAG_W-1:0]  mag_data,
    output logic [GAIN_W-1:0] gain,
    output logic              gain_valid,
    output logic              busy,
    output logic              err
);

    localparam int SUM_W = MAG_W + LOG2_NFFT;
    localparam int CNT_W = LOG2_NFFT + 1;
    localparam int TMO   = PIPE_LAT + 16;
    localparam int TMR_W = $clog2(TMO + 1);

    localparam logic [LOG2_NFFT-1:0] LAST_BIN = LOG2_NFFT'(NFFT - 1);
    localparam logic [TMR_W-1:0]     TMO_LAST = TMR_W'(TMO - 1);
    localparam logic [SUM_W-1:0]     GAIN_MAX = SUM_W'((1 << GAIN_W) - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        CAPTURE = 3'd2,
        DRAIN   = 3'd3,
        AVG     = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t               state;
    logic [LOG2_NFFT-1:0] bin_cnt;
    logic [CNT_W-1:0]     issued_cnt;
    logic [CNT_W-1:0]     result_cnt;
    logic [SUM_W-1:0]     sum;
    logic [TMR_W-1:0]     timer;
    logic [SUM_W-1:0]     avg;
    logic                 track;
    logic                 counts_match;

    // Datapath gating is zero-latency so the enable lines up with the bin on the bus.
    assign dp_ce        = (state == CAPTURE) && fft_valid;
    assign dp_in_valid  = dp_ce && !divisor_zero;
    assign track        = (state == CAPTURE) || (state == DRAIN);
    assign counts_match = (result_cnt == issued_cnt);
    assign avg          = sum >> LOG2_NFFT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            bin_cnt    <= '0;
            issued_cnt <= '0;
            result_cnt <= '0;
            sum        <= '0;
            timer      <= '0;
            gain       <= '0;
            gain_valid <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            gain_valid <= 1'b0;

            // A result with nothing outstanding is a pipeline fault; drop it.
            if (track && mag_valid) begin
                if (counts_match) begin
                    err <= 1'b1;
                end else begin
                    result_cnt <= result_cnt + CNT_W'(1);
                    sum        <= sum + SUM_W'(mag_data);
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ARM;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                    end
                end
                ARM: begin
                    if (fft_valid && fft_last) begin
                        state      <= CAPTURE;
                        bin_cnt    <= '0;
                        issued_cnt <= '0;
                        result_cnt <= '0;
                        sum        <= '0;
                        timer      <= '0;
                    end
                end
                CAPTURE: begin
                    if (fft_valid) begin
                        bin_cnt <= bin_cnt + LOG2_NFFT'(1);
                        if (!divisor_zero) begin
                            issued_cnt <= issued_cnt + CNT_W'(1);
                        end
                        if (fft_last && (bin_cnt == LAST_BIN)) begin
                            state <= DRAIN;
                        end else if (fft_last || (bin_cnt == LAST_BIN)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (counts_match) begin
                        state <= AVG;
                    end else if (timer == TMO_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                AVG: begin
                    if (avg > GAIN_MAX) begin
                        gain <= '1;
                    end else begin
                        gain <= avg[GAIN_W-1:0];
                    end
                    gain_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cal_frame_ctrl.sv
// Directed bench for cal_frame_ctrl with NFFT=16; a one-cycle-latency result model
// answers every issued bin so expected gains are hand-computed from the bin pattern.
module tb_cal_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        fft_valid = 1'b0;
    logic        fft_last = 1'b0;
    logic        divisor_zero = 1'b0;
    logic        dp_ce;
    logic        dp_in_valid;
    logic        mag_valid = 1'b0;
    logic [12:0] mag_data = '0;
    logic [11:0] gain;
    logic        gain_valid;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    int n_ce = 0;
    int n_iv = 0;
    int n_gv = 0;
    bit pend = 1'b0;

    cal_frame_ctrl #(
        .NFFT(16), .LOG2_NFFT(4), .PIPE_LAT(8), .MAG_W(13), .GAIN_W(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .fft_valid(fft_valid),
        .fft_last(fft_last), .divisor_zero(divisor_zero), .dp_ce(dp_ce),
        .dp_in_valid(dp_in_valid), .mag_valid(mag_valid), .mag_data(mag_data),
        .gain(gain), .gain_valid(gain_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dp_ce) n_ce++;
        if (dp_in_valid) n_iv++;
        if (gain_valid) n_gv++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Drive n bins back to back; results for issued bins return one cycle later.
    task automatic run_bins(input int n, input int last_idx, input logic [15:0] dz,
                            input logic [12:0] mv, input bit res_en, input int start_idx);
        for (int i = 0; i < n; i++) begin
            fft_valid    = 1'b1;
            fft_last     = (i == last_idx);
            divisor_zero = dz[i];
            start        = (i == start_idx);
            mag_valid    = pend;
            mag_data     = mv;
            pend         = res_en && !dz[i];
            step();
        end
        fft_valid    = 1'b0;
        fft_last     = 1'b0;
        divisor_zero = 1'b0;
        start        = 1'b0;
    endtask

    task automatic tail(input bit extra);
        mag_valid = pend;
        pend      = 1'b0;
        step();
        mag_valid = extra;
        step();
        mag_valid = 1'b0;
    endtask

    task automatic wait_gv(output bit seen);
        int k;
        k = 0;
        while (!gain_valid && k < 20) begin
            step();
            k++;
        end
        seen = gain_valid;
    endtask

    task automatic measure(input logic [15:0] dz, input logic [12:0] mv, input bit extra);
        pulse_start();
        run_bins(16, 15, 16'h0, mv, 1'b0, -1);
        run_bins(16, 15, dz, mv, 1'b1, -1);
        tail(extra);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (gain !== 12'd0) begin errors++; $display("FAIL reset_gain: got %0d want 0", gain); end
        checks++; if (gain_valid !== 1'b0) begin errors++; $display("FAIL reset_gain_valid: got %b want 0", gain_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (dp_ce !== 1'b0) begin errors++; $display("FAIL reset_dp_ce: got %b want 0", dp_ce); end
        checks++; if (dp_in_valid !== 1'b0) begin errors++; $display("FAIL reset_dp_in_valid: got %b want 0", dp_in_valid); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int b_ce, b_gv;
        bit seen;
        b_ce = n_ce;
        b_gv = n_gv;
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start: got %b want 1", busy); end
        run_bins(16, 15, 16'h0, 13'd100, 1'b0, -1);
        checks++; if (n_ce - b_ce !== 0) begin errors++; $display("FAIL basic_lead_dp_ce: got %0d want 0", n_ce - b_ce); end
        run_bins(16, 15, 16'h0, 13'd100, 1'b1, -1);
        tail(1'b0);
        wait_gv(seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL basic_gain_valid: got %b want 1", seen); end
        checks++; if (gain !== 12'd100) begin errors++; $display("FAIL basic_gain: got %0d want 100", gain); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_drop: got %b want 0", busy); end
        repeat (3) step();
        checks++; if (n_gv - b_gv !== 1) begin errors++; $display("FAIL basic_gv_count: got %0d want 1", n_gv - b_gv); end
        checks++; if (n_ce - b_ce !== 16) begin errors++; $display("FAIL basic_ce_count: got %0d want 16", n_ce - b_ce); end
    endtask

    task automatic test_zero_div();
        int b_iv;
        bit seen;
        b_iv = n_iv;
        measure(16'h1248, 13'd64, 1'b0);
        wait_gv(seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL zdiv_gain_valid: got %b want 1", seen); end
        checks++; if (gain !== 12'd48) begin errors++; $display("FAIL zdiv_gain: got %0d want 48", gain); end
        checks++; if (n_iv - b_iv !== 12) begin errors++; $display("FAIL zdiv_issue_count: got %0d want 12", n_iv - b_iv); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL zdiv_err: got %b want 0", err); end
        repeat (2) step();
    endtask

    task automatic test_short_frame();
        int b_gv;
        bit seen;
        b_gv = n_gv;
        pulse_start();
        run_bins(16, 15, 16'h0, 13'd100, 1'b0, -1);
        run_bins(11, 10, 16'h0, 13'd100, 1'b1, -1);
        tail(1'b0);
        repeat (4) step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL short_err: got %b want 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_busy: got %b want 0", busy); end
        checks++; if (gain !== 12'd48) begin errors++; $display("FAIL short_gain_kept: got %0d want 48", gain); end
        checks++; if (n_gv - b_gv !== 0) begin errors++; $display("FAIL short_no_gv: got %0d want 0", n_gv - b_gv); end
        pulse_start();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL short_err_cleared: got %b want 0", err); end
        run_bins(16, 15, 16'h0, 13'd100, 1'b0, -1);
        run_bins(16, 15, 16'h0, 13'd100, 1'b1, -1);
        tail(1'b0);
        wait_gv(seen);
        checks++; if (gain !== 12'd100) begin errors++; $display("FAIL short_recover_gain: got %0d want 100", gain); end
        repeat (2) step();
    endtask

    task automatic test_late_start();
        int b_ce;
        bit seen;
        b_ce = n_ce;
        run_bins(16, 15, 16'h0, 13'd50, 1'b0, 5);
        checks++; if (n_ce - b_ce !== 0) begin errors++; $display("FAIL late_no_dp_ce: got %0d want 0", n_ce - b_ce); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL late_busy: got %b want 1", busy); end
        run_bins(16, 15, 16'h0, 13'd32, 1'b1, -1);
        tail(1'b0);
        wait_gv(seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL late_gain_valid: got %b want 1", seen); end
        checks++; if (gain !== 12'd32) begin errors++; $display("FAIL late_gain: got %0d want 32", gain); end
        checks++; if (n_ce - b_ce !== 16) begin errors++; $display("FAIL late_ce_count: got %0d want 16", n_ce - b_ce); end
        repeat (2) step();
    endtask

    task automatic test_saturate();
        bit seen;
        measure(16'h0, 13'd8191, 1'b1);
        wait_gv(seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL sat_gain_valid: got %b want 1", seen); end
        checks++; if (gain !== 12'd4095) begin errors++; $display("FAIL sat_gain: got %0d want 4095", gain); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL sat_extra_err: got %b want 1", err); end
        repeat (2) step();
    endtask

    task automatic test_timeout();
        int b_gv, k;
        b_gv = n_gv;
        pulse_start();
        run_bins(16, 15, 16'h0, 13'd100, 1'b0, -1);
        run_bins(16, 15, 16'h0, 13'd100, 1'b0, -1);
        tail(1'b0);
        k = 0;
        while (busy && k < 100) begin
            step();
            k++;
        end
        checks++; if (k !== 22) begin errors++; $display("FAIL timeout_cycles: got %0d want 22", k); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", err); end
        checks++; if (n_gv - b_gv !== 0) begin errors++; $display("FAIL timeout_no_gv: got %0d want 0", n_gv - b_gv); end
        checks++; if (gain !== 12'd4095) begin errors++; $display("FAIL timeout_gain_kept: got %0d want 4095", gain); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        pulse_start();
        run_bins(16, 15, 16'h0, 13'd100, 1'b0, -1);
        run_bins(6, -1, 16'h0, 13'd100, 1'b1, -1);
        rst_n     = 1'b0;
        fft_valid = 1'b1;
        mag_valid = 1'b1;
        step();
        checks++; if (gain !== 12'd0) begin errors++; $display("FAIL rstmid_gain: got %0d want 0", gain); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b want 0", err); end
        checks++; if (dp_ce !== 1'b0) begin errors++; $display("FAIL rstmid_dp_ce: got %b want 0", dp_ce); end
        checks++; if (dp_in_valid !== 1'b0) begin errors++; $display("FAIL rstmid_dp_in_valid: got %b want 0", dp_in_valid); end
        checks++; if (gain_valid !== 1'b0) begin errors++; $display("FAIL rstmid_gain_valid: got %b want 0", gain_valid); end
        rst_n     = 1'b1;
        fft_valid = 1'b0;
        step();
        mag_valid = 1'b0;
        pend      = 1'b0;
        step();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid_stray_result_err: got %b want 0", err); end
        measure(16'h0, 13'd100, 1'b0);
        wait_gv(seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rstmid_gain_valid_after: got %b want 1", seen); end
        checks++; if (gain !== 12'd100) begin errors++; $display("FAIL rstmid_gain_after: got %0d want 100", gain); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid_err_after: got %b want 0", err); end
        repeat (2) step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_div();
        test_short_frame();
        test_late_start();
        test_saturate();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cal_frame_ctrl.md
# cal_frame_ctrl

Frame-level sequencer for the channel-gain calculation datapath: mult, divider pair, CORDIC square root. It arms on request and aligns to an FFT frame boundary. It gates the datapath clock-enable and divider tvalid per bin, tracks outstanding results through the pipeline, and accumulates the per-bin magnitudes. When the pipeline has drained, it publishes the frame-average gain with a one-cycle valid. It sits between the FFT output stream and the gain register, and replaces free-running bin counting with checked, handshaked frame control.

## Interface
- NFFT, 2048, bins per frame (power of two)
- LOG2_NFFT, 11, log2(NFFT)
- PIPE_LAT, 40, max cycles from bin issue to its mag_valid
- MAG_W, 13, magnitude width from CORDIC
- GAIN_W, 12, output gain width

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request one measurement (level or pulse; sampled in IDLE only)
- fft_valid  in  1  FFT bin valid
- fft_last  in  1  last bin of frame, qualified by fft_valid
- divisor_zero  in  1  |X|^2 == 0 for current bin, qualified by fft_valid
- dp_ce  out  1  datapath multiplier clock-enable
- dp_in_valid  out  1  divider dividend tvalid
- mag_valid  in  1  CORDIC result valid
- mag_data  in  MAG_W  CORDIC magnitude
- gain  out  GAIN_W  last good frame-average gain
- gain_valid  out  1  one-cycle pulse when gain updates
- busy  out  1  high in every state except IDLE
- err  out  1  sticky frame/pipeline error, cleared on accepted start

## Operation
- States: IDLE, ARM, CAPTURE, DRAIN, AVG, DONE.
- IDLE: start=1 -> ARM; err cleared on that cycle.
- ARM: wait for fft_valid&fft_last (frame boundary) -> CAPTURE. Bins before and including that last are not processed.
- CAPTURE:
  - dp_ce = fft_valid; dp_in_valid = fft_valid & ~divisor_zero (both combinational, zero latency).
  - bin_cnt increments per fft_valid; issued_cnt increments per dp_in_valid.
  - fft_valid&fft_last with bin_cnt==NFFT-1 -> DRAIN.
- Frame errors: fft_last with bin_cnt!=NFFT-1 -> err=1, go IDLE. bin_cnt reaching NFFT-1 without fft_last also -> err=1, go IDLE. In both cases gain is unchanged.
- Result tracking, active in CAPTURE and DRAIN:
  - Each mag_valid adds mag_data to sum (width MAG_W+LOG2_NFFT) and increments result_cnt.
  - mag_valid when result_cnt==issued_cnt -> err=1; the result is discarded.
- Zero-divisor bins contribute 0 to sum but count toward NFFT in the denominator.
- DRAIN: result_cnt==issued_cnt -> AVG. Timeout counter: after PIPE_LAT+16 cycles in DRAIN -> err=1, go IDLE.
- AVG: avg = sum >> LOG2_NFFT; if avg > 2^GAIN_W-1, saturate to 2^GAIN_W-1; register into gain -> DONE.
- DONE: gain_valid=1 for one cycle -> IDLE.
- mag_valid in IDLE/ARM is ignored (no sum update, no err).
- start outside IDLE is ignored.
- All counters and sum clear on entry to CAPTURE.

## Timing
- Reset values: gain=0, gain_valid=0, busy=0, err=0, dp_ce=0, dp_in_valid=0; state=IDLE; all counters and sum=0.
- Reset mid-operation: the reset values above apply on the next edge; any in-flight pipeline results after reset are ignored (state IDLE).
- start sampled in IDLE -> busy=1 from the next cycle.
- Simultaneous fft_valid and mag_valid in CAPTURE: both counters and sum update in the same cycle.
- mag_valid on the same cycle as the CAPTURE->DRAIN transition is counted.
- Latency from last result accepted to gain_valid: 2 cycles (DRAIN->AVG, AVG->DONE). gain is stable on and after the gain_valid cycle.
- DRAIN exits on the cycle after the counts match.

## Test plan
- NFFT=16/LOG2_NFFT=4, start, one lead frame then a full frame, mag_data=100 for all bins -> exactly one gain_valid, gain=100, err=0, busy drops the cycle after gain_valid.
- Same setup, 4 bins divisor_zero=1, other 12 mag=64 -> dp_in_valid count=12, sum=768, gain=48.
- fft_last at bin 10 in CAPTURE -> err=1, no gain_valid, gain keeps prior value 48, state IDLE; next start clears err.
- start asserted at bin 5 of a running stream -> no dp_ce until after the next fft_last; the following full frame is measured.
- All mag_data=8191 -> gain=4095 (saturated); extra mag_valid injected in DRAIN -> err=1.
- rst_n=0 for one cycle mid-CAPTURE -> all outputs 0 next cycle, then a new start gives a correct gain.
